pdm_clk_ctrl: RTL and testbench

PDM_CLK_CTRL -- requirements
Module: pdm_clk_ctrl

---
 rtl/pdm_clk_pkg.sv | 41 ++++
 rtl/pdm_strobe_dly.sv | 31 +++
 rtl/pdm_clk_ctrl.sv | 147 ++++++++++++++
 tb/tb_pdm_clk_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pdm_clk_pkg.sv
// Shared types and the MIC_CLK mode table for the PDM microphone clock controller.
// Table entries are high/low phase lengths in 100 MHz system clock cycles.
package pdm_clk_pkg;

  typedef enum logic [1:0] {StIdle, StHigh, StLow} pdm_state_e;

  typedef struct packed {
    logic [7:0] hi_cnt;
    logic [7:0] lo_cnt;
  } mode_cfg_t;

  localparam int unsigned NumTableModes = 4;

  localparam mode_cfg_t MODE_TABLE [NumTableModes] = '{
    '{hi_cnt: 8'd16, lo_cnt: 8'd17},  // 3.03 MHz
    '{hi_cnt: 8'd21, lo_cnt: 8'd21},  // 2.38 MHz
    '{hi_cnt: 8'd49, lo_cnt: 8'd49},  // 1.02 MHz
    '{hi_cnt: 8'd65, lo_cnt: 8'd65}   // 769 kHz
  };

  function automatic int unsigned max_phase(input int unsigned n);
    int unsigned m;
    m = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (32'(MODE_TABLE[i].hi_cnt) > m) m = 32'(MODE_TABLE[i].hi_cnt);
      if (32'(MODE_TABLE[i].lo_cnt) > m) m = 32'(MODE_TABLE[i].lo_cnt);
    end
    return m;
  endfunction

  function automatic int unsigned min_phase(input int unsigned n);
    int unsigned m;
    m = 255;
    for (int unsigned i = 0; i < n; i++) begin
      if (32'(MODE_TABLE[i].hi_cnt) < m) m = 32'(MODE_TABLE[i].hi_cnt);
      if (32'(MODE_TABLE[i].lo_cnt) < m) m = 32'(MODE_TABLE[i].lo_cnt);
    end
    return m;
  endfunction

endpackage

// File: rtl/pdm_strobe_dly.sv
// Single-bit pulse delay line: stb_o repeats stb_i Delay cycles later (combinational at 0).
module pdm_strobe_dly #(
  parameter int unsigned Delay = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stb_i,
  output logic stb_o
);

  if (Delay == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign stb_o = stb_i;
  end else if (Delay == 1) begin : g_one
    logic stb_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stb_q <= 1'b0;
      else         stb_q <= stb_i;
    end
    assign stb_o = stb_q;
  end else begin : g_pipe
    logic [Delay-1:0] sr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sr_q <= '0;
      else         sr_q <= {sr_q[Delay-2:0], stb_i};
    end
    assign stb_o = sr_q[Delay-1];
  end

endmodule

// File: rtl/pdm_clk_ctrl.sv
// PDM microphone clock generator: table-driven high/low phases, edge strobes,
// delayed per-channel sample strobes and a decimation frame strobe.
module pdm_clk_ctrl
  import pdm_clk_pkg::*;
#(
  parameter int unsigned NUM_MODES  = 4,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SAMPLE_DLY = 2,
  parameter int unsigned DECIM      = 64,
  localparam int unsigned SelW      = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [SelW-1:0]   div_sel,
  output logic              MIC_CLK,
  output logic              rise_stb,
  output logic              fall_stb,
  output logic [NUM_CH-1:0] smp_stb,
  output logic              pcm_stb,
  output logic              running,
  output logic [SelW-1:0]   cur_sel
);

  localparam int unsigned MaxPhase = max_phase(NUM_MODES);
  localparam int unsigned MinPhase = min_phase(NUM_MODES);
  localparam int unsigned CntW     = $clog2(MaxPhase);
  localparam int unsigned DecW     = $clog2(DECIM);
  localparam logic [DecW-1:0] DecLast = DecW'(DECIM - 1);

  if (NUM_MODES < 1 || NUM_MODES > NumTableModes) begin : g_bad_modes
    $error("NUM_MODES out of range of MODE_TABLE");
  end
  if (NUM_CH < 1 || NUM_CH > 2) begin : g_bad_ch
    $error("NUM_CH must be 1 or 2");
  end
  if (DECIM < 2 || DECIM > 1024) begin : g_bad_decim
    $error("DECIM must be 2 to 1024");
  end
  if (SAMPLE_DLY > 15 || SAMPLE_DLY >= MinPhase) begin : g_bad_dly
    $error("SAMPLE_DLY must be below every hi_cnt/lo_cnt in MODE_TABLE");
  end
  if (MinPhase < 2) begin : g_bad_table
    $error("MODE_TABLE phases must be at least 2 cycles");
  end

  pdm_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [DecW-1:0] dec_q, dec_d;
  logic            mic_q, rise_q, fall_q, pcm_q;
  logic            rise_d, fall_d;
  mode_cfg_t       cfg;
  logic [CntW-1:0] hi_last, lo_last;

  // Phase lengths of the period in progress; sel_q only moves on a rising edge.
  assign cfg     = MODE_TABLE[sel_q];
  assign hi_last = CntW'(cfg.hi_cnt - 8'd1);
  assign lo_last = CntW'(cfg.lo_cnt - 8'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    dec_d   = dec_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StHigh;
          rise_d  = 1'b1;
          sel_d   = div_sel;
          cnt_d   = '0;
          dec_d   = '0;
        end
      end
      StHigh: begin
        if (cnt_q == hi_last) begin
          state_d = StLow;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLow: begin
        if (cnt_q == lo_last) begin
          cnt_d = '0;
          // en only matters once the low phase is complete, so periods never truncate.
          if (en) begin
            state_d = StHigh;
            rise_d  = 1'b1;
            sel_d   = div_sel;
            dec_d   = (dec_q == DecLast) ? '0 : dec_q + DecW'(1);
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      dec_q   <= '0;
      mic_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pcm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dec_q   <= dec_d;
      mic_q   <= (state_d == StHigh);
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pcm_q   <= rise_d && (dec_d == DecLast);
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pdm_strobe_dly #(
      .Delay (SAMPLE_DLY)
    ) u_dly (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .stb_i  ((ch == 0) ? rise_q : fall_q),
      .stb_o  (smp_stb[ch])
    );
  end

  assign MIC_CLK  = mic_q;
  assign rise_stb = rise_q;
  assign fall_stb = fall_q;
  assign pcm_stb  = pcm_q;
  assign running  = (state_q != StIdle);
  assign cur_sel  = sel_q;

endmodule

// File: tb/tb_pdm_clk_ctrl.sv
// Bench for pdm_clk_ctrl: directed and random en/div_sel stimulus checked every cycle
// against a period-position model of the MIC_CLK waveform and its strobes.
module tb_pdm_clk_ctrl;

  localparam int unsigned NM   = 4;
  localparam int unsigned NC   = 2;
  localparam int unsigned SD   = 2;
  localparam int unsigned DC   = 4;
  localparam int          MAXC = 16384;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    div_sel = 2'd0;
  logic          mic, rise, fall, pcm, running;
  logic [NC-1:0] smp;
  logic [1:0]    cur_sel;

  always #5 clk = ~clk;

  pdm_clk_ctrl #(
    .NUM_MODES  (NM),
    .NUM_CH     (NC),
    .SAMPLE_DLY (SD),
    .DECIM      (DC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_sel  (div_sel),
    .MIC_CLK  (mic),
    .rise_stb (rise),
    .fall_stb (fall),
    .smp_stb  (smp),
    .pcm_stb  (pcm),
    .running  (running),
    .cur_sel  (cur_sel)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int hi_tab [4] = '{16, 21, 49, 65};
  int lo_tab [4] = '{17, 21, 49, 65};

  // Model: a period starts at m_start; MIC_CLK is high for the first m_hi cycles of it.
  bit         m_run = 1'b0;
  int         m_start = 0;
  int         m_hi = 16;
  int         m_lo = 17;
  int         m_rises = 0;
  logic [1:0] m_sel = 2'd0;
  bit         rise_at [MAXC];
  bit         fall_at [MAXC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_sel   = 2'd0;
    m_rises = 0;
    for (int i = 0; i < MAXC; i++) begin
      rise_at[i] = 1'b0;
      fall_at[i] = 1'b0;
    end
  endtask

  task automatic start_period(input logic [1:0] sel_s, input bit from_idle);
    m_run   = 1'b1;
    m_start = cyc;
    m_sel   = sel_s;
    m_hi    = hi_tab[sel_s];
    m_lo    = lo_tab[sel_s];
    m_rises = from_idle ? 1 : m_rises + 1;
    if (cyc < MAXC) rise_at[cyc] = 1'b1;
    if (cyc + m_hi < MAXC) fall_at[cyc + m_hi] = 1'b1;
  endtask

  task automatic model_edge(input logic en_s, input logic [1:0] sel_s);
    if (!m_run) begin
      if (en_s) start_period(sel_s, 1'b1);
    end else if (cyc - m_start == m_hi + m_lo) begin
      if (en_s) start_period(sel_s, 1'b0);
      else      m_run = 1'b0;
    end
  endtask

  task automatic check_outputs();
    int pos;
    bit e_rise;
    pos    = cyc - m_start;
    e_rise = m_run && (pos == 0);
    chk("mic_clk",  32'(mic),     32'(m_run && pos < m_hi));
    chk("rise_stb", 32'(rise),    32'(e_rise));
    chk("fall_stb", 32'(fall),    32'(m_run && pos == m_hi));
    chk("pcm_stb",  32'(pcm),     32'(e_rise && (m_rises % DC == 0)));
    chk("running",  32'(running), 32'(m_run));
    chk("cur_sel",  32'(cur_sel), 32'(m_sel));
    chk("smp0",     32'(smp[0]),  32'(cyc >= SD && rise_at[cyc - SD]));
    chk("smp1",     32'(smp[1]),  32'(cyc >= SD && fall_at[cyc - SD]));
    chk("smp_both", 32'(smp[0] & smp[1]), 32'(0));
  endtask

  // One clock: inputs already set, model follows the edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(en, div_sel);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // Mode 0: 16 high / 17 low.
    en = 1'b1;
    div_sel = 2'd0;
    step();
    chk("first_rise", 32'(rise), 32'(1));
    repeat (70) step();

    // div_sel change in cycle 5 of HIGH applies from the next rise.
    for (int i = 0; i < 100 && !(m_run && cyc - m_start == 4); i++) step();
    chk("wait_hi5_mic", 32'(mic), 32'(1));
    div_sel = 2'd2;
    repeat (150) step();

    // en dropped mid-HIGH: period completes, then IDLE.
    for (int i = 0; i < 200 && !(m_run && m_sel == 2'd2 && cyc - m_start == 20); i++) step();
    chk("wait_mode2_mic", 32'(mic), 32'(1));
    en = 1'b0;
    repeat (100) step();
    chk("idle_running", 32'(running), 32'(0));

    // Decimation: mode 1, then an off/on restart.
    div_sel = 2'd1;
    en = 1'b1;
    repeat (42 * 13) step();
    en = 1'b0;
    for (int i = 0; i < 200 && m_run; i++) step();
    chk("idle_after_dec", 32'(running), 32'(0));
    repeat (4) step();
    en = 1'b1;
    repeat (42 * 5) step();

    // Reset pulse during LOW: outputs drop at once, restart right after release.
    for (int i = 0; i < 200 && !(m_run && cyc - m_start == m_hi + 5); i++) step();
    chk("wait_low_mic", 32'(mic), 32'(0));
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    step();
    chk("restart_mic", 32'(mic), 32'(1));
    repeat (60) step();

    // Random en toggling and div_sel churn.
    repeat (3000) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      div_sel = 2'($urandom_range(0, 3));
      step();
    end

    en = 1'b0;
    for (int i = 0; i < 300 && m_run; i++) step();
    repeat (4) step();
    chk("final_idle", 32'(running), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
